// File: rtl/saradc_11b_dig_sucal.sv
// Start-up comparator offset calibration: shorts the comparator inputs and
// SAR-searches a trim code, one majority-voted decision per trim bit.
module saradc_11b_dig_sucal #(
    parameter int TRIM_W     = 6,
    parameter int SETTLE_CYC = 7,
    parameter int VOTES      = 5
) (
    input  logic              clk,
    input  logic              res,
    input  logic              enable_fsms_i,
    input  logic              sucal_i,
    input  logic              comp_i,
    output logic [TRIM_W-1:0] trim_o,
    output logic              cal_short_o,
    output logic              cal_busy_o,
    output logic              sucal_done_o
);

    localparam int BW = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int VW = (VOTES > 1) ? $clog2(VOTES) : 1;
    localparam int OW = $clog2(VOTES + 1);

    localparam logic [BW-1:0]     BIT_MSB   = BW'(TRIM_W - 1);
    localparam logic [CW-1:0]     CNT_INIT  = CW'(SETTLE_CYC - 1);
    localparam logic [VW-1:0]     VCNT_INIT = VW'(VOTES - 1);
    localparam logic [TRIM_W-1:0] TRIM_MSB  = TRIM_W'(1) << (TRIM_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIAL,
        S_SAMPLE,
        S_DECIDE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [TRIM_W-1:0] trim_q, trim_d;
    logic [BW-1:0]     bit_idx_q, bit_idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [VW-1:0]     vcnt_q, vcnt_d;
    logic [OW-1:0]     ones_q, ones_d;
    logic              short_q, short_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q   <= S_IDLE;
            trim_q    <= '0;
            bit_idx_q <= '0;
            cnt_q     <= '0;
            vcnt_q    <= '0;
            ones_q    <= '0;
            short_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            trim_q    <= trim_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            vcnt_q    <= vcnt_d;
            ones_q    <= ones_d;
            short_q   <= short_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        // NOTE: every next-state signal defaults to its held value first so no path infers a latch.
        state_d   = state_q;
        trim_d    = trim_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        vcnt_d    = vcnt_q;
        ones_d    = ones_q;
        short_d   = short_q;
        busy_d    = busy_q;
        done_d    = done_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (sucal_i) begin
                    trim_d    = TRIM_MSB;
                    bit_idx_d = BIT_MSB;
                    cnt_d     = CNT_INIT;
                    short_d   = 1'b1;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    state_d   = S_TRIAL;
                end
            end
            S_TRIAL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    vcnt_d  = VCNT_INIT;
                    ones_d  = '0;
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                ones_d = ones_q + OW'(comp_i);
                if (vcnt_q == '0) state_d = S_DECIDE;
                else              vcnt_d  = vcnt_q - 1'b1;
            end
            S_DECIDE: begin
                // Majority of "trim still too low" votes keeps the trial bit.
                if (int'(ones_q) <= VOTES / 2) trim_d[bit_idx_q] = 1'b0;
                if (bit_idx_q == '0) begin
                    short_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    bit_idx_d                 = bit_idx_q - 1'b1;
                    trim_d[bit_idx_q - 1'b1]  = 1'b1;
                    cnt_d                     = CNT_INIT;
                    state_d                   = S_TRIAL;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Losing the start-up FSM enable aborts everything, including a same-cycle start.
        if (!enable_fsms_i) begin
            state_d   = S_IDLE;
            trim_d    = '0;
            bit_idx_d = '0;
            cnt_d     = '0;
            vcnt_d    = '0;
            ones_d    = '0;
            short_d   = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
        end
    end

    assign trim_o       = trim_q;
    assign cal_short_o  = short_q;
    assign cal_busy_o   = busy_q;
    assign sucal_done_o = done_q;

endmodule

// File: tb/tb_saradc_11b_dig_sucal.sv
// Directed bench for the start-up offset calibration sequencer (default parameters).
module tb_saradc_11b_dig_sucal;

    logic       clk = 1'b0;
    logic       res;
    logic       enable_fsms_i;
    logic       sucal_i;
    logic       comp_i;
    logic [5:0] trim_o;
    logic       cal_short_o;
    logic       cal_busy_o;
    logic       sucal_done_o;

    int n_cmp = 0;
    int n_bad = 0;

    saradc_11b_dig_sucal dut (
        .clk           (clk),
        .res           (res),
        .enable_fsms_i (enable_fsms_i),
        .sucal_i       (sucal_i),
        .comp_i        (comp_i),
        .trim_o        (trim_o),
        .cal_short_o   (cal_short_o),
        .cal_busy_o    (cal_busy_o),
        .sucal_done_o  (sucal_done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Comparator stimulus. v is the vote index within a SAMPLE window of bit step b.
    function automatic logic comp_model(input int mode, input logic [5:0] trim, input int b, input int v);
        case (mode)
            1:       return 1'b1;
            2:       return trim <= 6'd37;
            3:       return (b == 0) && (v >= 0) && (v <= 2);
            4:       return (b == 0) && (v >= 0) && (v <= 1);
            default: return 1'b0;
        endcase
    endfunction

    // Pulse sucal_i, run one calibration and check latency, flags and result.
    task automatic run_cal(input int mode, input int pulse_k, input logic [5:0] exp_trim, input string tag);
        int         lat;
        bit         busy_ok;
        logic [5:0] trials [6];
        int         b, p;
        @(negedge clk);
        sucal_i = 1'b1;
        comp_i  = 1'b0;
        @(negedge clk);
        sucal_i = 1'b0;
        check({tag, " start"}, {sucal_done_o, cal_busy_o, cal_short_o, trim_o}, {3'b011, 6'd32});
        lat     = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 200 && lat == 0; k++) begin
            b = (k - 1) / 13;
            p = (k - 1) % 13;
            if (p == 0 && b < 6) trials[b] = trim_o;
            comp_i  = comp_model(mode, trim_o, b, p - 7);
            sucal_i = (k == pulse_k);
            @(negedge clk);
            if (sucal_done_o) lat = k;
            else if (!(cal_busy_o && cal_short_o)) busy_ok = 1'b0;
        end
        sucal_i = 1'b0;
        comp_i  = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'd78);
        check({tag, " busy_while_running"}, 64'(busy_ok), 64'd1);
        check({tag, " flags_at_done"}, {cal_busy_o, cal_short_o}, 2'b00);
        check({tag, " trim"}, 64'(trim_o), 64'(exp_trim));
        if (mode == 2)
            check({tag, " trials"}, {trials[0], trials[1], trials[2], trials[3], trials[4], trials[5]},
                  {6'd32, 6'd48, 6'd40, 6'd36, 6'd38, 6'd37});
        @(negedge clk);
        check({tag, " done_held"}, {sucal_done_o, trim_o}, {1'b1, exp_trim});
    endtask

    initial begin
        res           = 1'b1;
        enable_fsms_i = 1'b1;
        sucal_i       = 1'b0;
        comp_i        = 1'b0;
        #1;
        check("reset", {sucal_done_o, cal_busy_o, cal_short_o, trim_o}, 9'd0);
        @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {sucal_done_o, cal_busy_o, cal_short_o, trim_o}, 9'd0);

        run_cal(1, 0, 6'd63, "all_ones");
        // Restart from DONE: start check inside run_cal covers done going low.
        run_cal(0, 0, 6'd0,  "restart_all_zeros");
        run_cal(2, 0, 6'd37, "model37");
        run_cal(3, 0, 6'd32, "vote_3_of_5");
        run_cal(4, 0, 6'd0,  "vote_2_of_5");
        run_cal(2, 13, 6'd37, "pulse_in_decide");

        // Abort during SAMPLE of bit 3 together with a start pulse.
        @(negedge clk);
        sucal_i = 1'b1;
        comp_i  = 1'b1;
        @(negedge clk);
        sucal_i = 1'b0;
        repeat (33) @(negedge clk);
        check("abort_pre_trim", {cal_busy_o, trim_o}, {1'b1, 6'd56});
        enable_fsms_i = 1'b0;
        sucal_i       = 1'b1;
        @(negedge clk);
        check("abort_outputs", {sucal_done_o, cal_busy_o, cal_short_o, trim_o}, 9'd0);
        enable_fsms_i = 1'b1;
        sucal_i       = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_stays_idle", {sucal_done_o, cal_busy_o, cal_short_o, trim_o}, 9'd0);
        run_cal(1, 0, 6'd63, "rerun_after_abort");

        // Asynchronous reset between clock edges during TRIAL.
        @(negedge clk);
        sucal_i = 1'b1;
        @(negedge clk);
        sucal_i = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_async_busy", {cal_busy_o, cal_short_o, trim_o}, {2'b11, 6'd32});
        #2;
        res = 1'b1;
        #1;
        check("async_reset", {sucal_done_o, cal_busy_o, cal_short_o, trim_o}, 9'd0);
        @(negedge clk);
        res = 1'b0;
        repeat (2) @(negedge clk);
        check("after_async_idle", {sucal_done_o, cal_busy_o, cal_short_o, trim_o}, 9'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
